// File: rtl/effect_param_arbiter_if.sv
// Bundles the requester, entry-engine and parameter-register signals of the effect arbiter.
// Latency: none, wires only.
// Backpressure: none; set_req is level-held by the requester and the arbiter owns the entry engine while granted.
interface effect_param_arbiter_if;
  logic [2:0] effect_on;
  logic [2:0] set_req;
  logic       entry_done;
  logic [9:0] entry_value;
  logic       entry_start;
  logic [2:0] grant;
  logic       busy;
  logic [6:0] volume_data;
  logic [6:0] pitch_data;
  logic [6:0] distortion_data;
  logic [2:0] param_update;
  logic       timeout_err;

  // Arbiter side
  modport slave (
    input  effect_on, set_req, entry_done, entry_value,
    output entry_start, grant, busy, volume_data, pitch_data, distortion_data,
           param_update, timeout_err
  );

  // Requester / environment side
  modport master (
    output effect_on, set_req, entry_done, entry_value,
    input  entry_start, grant, busy, volume_data, pitch_data, distortion_data,
           param_update, timeout_err
  );
endinterface

// File: rtl/effect_param_arbiter.sv
// Round-robin arbiter sharing one keypad entry engine among volume/pitch/distortion; commits clamped values.
// Latency: grant one cycle after a valid request; value visible in the cycle after entry_done (COMMIT).
// Backpressure: requests wait in IDLE while busy; RELEASE holds until the owner drops set_req.
// Optional watchdog: define EFFECT_ARB_TIMEOUT_EN to abandon an entry after TIMEOUT_CYCLES cycles.
module effect_param_arbiter #(
  parameter logic [27:0] TIMEOUT_CYCLES = 28'd250000000
) (
  input logic                    Clock,
  input logic                    Reset,
  effect_param_arbiter_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [6:0] volume_q, volume_d;
  logic [6:0] pitch_q, pitch_d;
  logic [6:0] dist_q, dist_d;
  logic       terr_q, terr_d;

  logic [2:0] valid;
  logic [2:0] owner_oh;
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] winner;
  logic       any_valid;
  logic [6:0] clamped;
  logic       timeout_hit;
  logic       cancel;

  // Modulo-3 increment; the pointer and owner index never take the value 3.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign valid    = bus.set_req & bus.effect_on;
  assign owner_oh = 3'b001 << owner_q;
  assign cancel   = ~bus.effect_on[owner_q];
  // Compare the full 10-bit value so 101..999 saturate instead of wrapping.
  assign clamped  = (bus.entry_value > 10'd100) ? 7'd100 : bus.entry_value[6:0];

`ifdef EFFECT_ARB_TIMEOUT_EN
  logic [27:0] cnt_q, cnt_d;
  assign timeout_hit = (cnt_q == TIMEOUT_CYCLES - 28'd1);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Round-robin pick: scan pointer, pointer+1, pointer+2 and take the first valid requester.
  always_comb begin
    cand0     = ptr_q;
    cand1     = inc3(cand0);
    cand2     = inc3(cand1);
    winner    = cand0;
    any_valid = 1'b1;
    if (valid[cand0])      winner = cand0;
    else if (valid[cand1]) winner = cand1;
    else if (valid[cand2]) winner = cand2;
    else                   any_valid = 1'b0;
  end

  // Next-state, ownership, register write and watchdog logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    volume_d = volume_q;
    pitch_d  = pitch_q;
    dist_d   = dist_q;
    terr_d   = terr_q;
`ifdef EFFECT_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d = S_GRANT;
          owner_d = winner;
          ptr_d   = inc3(winner);
          terr_d  = 1'b0;
        end
      end
      S_GRANT: begin
`ifdef EFFECT_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = cancel ? S_RELEASE : S_WAIT;
      end
      S_WAIT: begin
        // Priority: cancel, then a completed entry, then watchdog expiry.
        if (cancel) begin
          state_d = S_RELEASE;
        end else if (bus.entry_done) begin
          state_d = S_COMMIT;
          case (owner_q)
            2'd0:    volume_d = clamped;
            2'd1:    pitch_d  = clamped;
            default: dist_d   = clamped;
          endcase
        end else if (timeout_hit) begin
          state_d = S_RELEASE;
          terr_d  = 1'b1;
        end else begin
`ifdef EFFECT_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 28'd1;
`endif
        end
      end
      S_COMMIT: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the button to drop so a held request cannot retrigger.
        if (!bus.set_req[owner_q]) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      volume_q <= 7'd0;
      pitch_q  <= 7'd0;
      dist_q   <= 7'd0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      volume_q <= volume_d;
      pitch_q  <= pitch_d;
      dist_q   <= dist_d;
      terr_q   <= terr_d;
    end
  end

`ifdef EFFECT_ARB_TIMEOUT_EN
  // Watchdog counter register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Outputs decode from state so reset clears them without a clock edge.
  assign bus.entry_start     = (state_q == S_GRANT);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.grant           = ((state_q == S_GRANT) || (state_q == S_WAIT) ||
                                (state_q == S_COMMIT)) ? owner_oh : 3'b000;
  assign bus.param_update    = (state_q == S_COMMIT) ? owner_oh : 3'b000;
  assign bus.volume_data     = volume_q;
  assign bus.pitch_data      = pitch_q;
  assign bus.distortion_data = dist_q;
  assign bus.timeout_err     = terr_q;

endmodule

// File: tb/tb_effect_param_arbiter.sv
// Directed bench for effect_param_arbiter with TIMEOUT_CYCLES = 16.
// Timeout expectations follow EFFECT_ARB_TIMEOUT_EN when it is defined for the build.
module tb_effect_param_arbiter;
  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  logic [6:0] exp_d [3];

  effect_param_arbiter_if bus ();

  effect_param_arbiter #(.TIMEOUT_CYCLES(28'd16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  function automatic logic [6:0] clamp100(input logic [9:0] v);
    return (v > 10'd100) ? 7'd100 : v[6:0];
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_vol"},  32'(bus.volume_data),     32'(exp_d[0]));
    check({tag, "_pit"},  32'(bus.pitch_data),      32'(exp_d[1]));
    check({tag, "_dist"}, 32'(bus.distortion_data), 32'(exp_d[2]));
  endtask

  // Called at a negedge in the GRANT cycle; returns at a negedge in IDLE.
  task automatic serve(input int idx, input logic [9:0] val);
    logic [2:0] oh;
    oh = 3'b000;
    oh[idx] = 1'b1;
    check("grant_g",  32'(bus.grant), 32'(oh));
    check("start_g",  32'(bus.entry_start), 32'd1);
    check("busy_g",   32'(bus.busy), 32'd1);
    tick();
    check("grant_w",  32'(bus.grant), 32'(oh));
    check("start_w",  32'(bus.entry_start), 32'd0);
    check("upd_w",    32'(bus.param_update), 32'd0);
    bus.entry_done  = 1'b1;
    bus.entry_value = val;
    tick();
    bus.entry_done  = 1'b0;
    exp_d[idx] = clamp100(val);
    check("upd_c",    32'(bus.param_update), 32'(oh));
    check("grant_c",  32'(bus.grant), 32'(oh));
    check_regs("commit");
    bus.set_req[idx] = 1'b0;
    tick();
    check("grant_r",  32'(bus.grant), 32'd0);
    check("upd_r",    32'(bus.param_update), 32'd0);
    check("busy_r",   32'(bus.busy), 32'd1);
    tick();
    check("busy_i",   32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_start"}, 32'(bus.entry_start), 32'd0);
    check({tag, "_upd"},   32'(bus.param_update), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_terr"},  32'(bus.timeout_err), 32'd0);
    check({tag, "_vol"},   32'(bus.volume_data), 32'd0);
    check({tag, "_pit"},   32'(bus.pitch_data), 32'd0);
    check({tag, "_dist"},  32'(bus.distortion_data), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) exp_d[i] = 7'd0;
    Reset           = 1'b0;
    bus.effect_on   = 3'b000;
    bus.set_req     = 3'b000;
    bus.entry_done  = 1'b0;
    bus.entry_value = 10'd0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    Reset = 1'b1;
    tick();

    // Single volume request with value 42; set_req is a one-cycle pulse.
    bus.effect_on = 3'b001;
    bus.set_req   = 3'b001;
    tick();
    bus.set_req   = 3'b000;
    serve(0, 10'd42);

    // Reset with all requesters held: pointer restarts at volume, then rotates.
    bus.effect_on = 3'b111;
    bus.set_req   = 3'b111;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_d[i] = 7'd0;
    #1;
    check_all_zero("reset2");
    tick();
    Reset = 1'b1;
    tick();
    serve(0, 10'd7);
    bus.set_req[0] = 1'b1;
    tick();
    serve(1, 10'd999);
    bus.set_req[1] = 1'b1;
    tick();
    serve(2, 10'd101);
    bus.set_req[2] = 1'b1;
    tick();
    serve(0, 10'd100);
    bus.set_req = 3'b000;
    tick();

    // Distortion cancelled in the same cycle as entry_done: no write.
    bus.effect_on = 3'b100;
    bus.set_req   = 3'b100;
    tick();
    check("cx_grant", 32'(bus.grant), 32'd4);
    tick();
    bus.entry_done  = 1'b1;
    bus.entry_value = 10'd50;
    bus.effect_on   = 3'b000;
    tick();
    bus.entry_done  = 1'b0;
    check("cx_upd",   32'(bus.param_update), 32'd0);
    check("cx_grant_r", 32'(bus.grant), 32'd0);
    check("cx_busy",  32'(bus.busy), 32'd1);
    check_regs("cancel");
    tick();
    check("cx_hold",  32'(bus.busy), 32'd1);
    bus.set_req = 3'b000;
    tick();
    check("cx_idle",  32'(bus.busy), 32'd0);

    // Volume granted with no entry completion.
    bus.effect_on = 3'b001;
    bus.set_req   = 3'b001;
    tick();
    bus.set_req   = 3'b000;
    tick();
`ifdef EFFECT_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("to_early", 32'(bus.timeout_err), 32'd0);
    check("to_grant", 32'(bus.grant), 32'd1);
    tick();
    check("to_err",   32'(bus.timeout_err), 32'd1);
    check("to_grant_r", 32'(bus.grant), 32'd0);
    check("to_upd",   32'(bus.param_update), 32'd0);
    check_regs("timeout");
    tick();
    check("to_idle",  32'(bus.busy), 32'd0);
    check("to_sticky", 32'(bus.timeout_err), 32'd1);
`else
    for (int i = 0; i < 40; i++) tick();
    check("nto_grant", 32'(bus.grant), 32'd1);
    check("nto_busy",  32'(bus.busy), 32'd1);
    check("nto_err",   32'(bus.timeout_err), 32'd0);
    bus.entry_done  = 1'b1;
    bus.entry_value = 10'd3;
    tick();
    bus.entry_done  = 1'b0;
    exp_d[0] = 7'd3;
    check_regs("nto");
    tick();
    tick();
    check("nto_idle",  32'(bus.busy), 32'd0);
`endif
    bus.set_req = 3'b001;
    tick();
    check("terr_clr", 32'(bus.timeout_err), 32'd0);
    serve(0, 10'd55);

    // Reset during WAIT_ENTRY with volume_data = 55: asynchronous clear.
    bus.set_req = 3'b001;
    tick();
    bus.set_req = 3'b000;
    tick();
    check("pre_vol",  32'(bus.volume_data), 32'd55);
    bus.entry_done  = 1'b1;
    bus.entry_value = 10'd9;
    #2;
    Reset = 1'b0;
    #1;
    check_all_zero("arst");
    tick();
    bus.entry_done = 1'b0;
    Reset = 1'b1;
    tick();
    check("post_busy", 32'(bus.busy), 32'd0);
    check("post_vol",  32'(bus.volume_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
